// File: rtl/minibyte_pkg.sv
// minibyte bus arbiter shared definitions
// state encoding, requester ids, bus width
package minibyte_pkg;

  localparam int DW = 8;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic          id;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

endpackage

// File: rtl/minibyte_rr_pick.sv
// minibyte two-way round-robin pick
// on a tie the requester not served last wins
module minibyte_rr_pick
  import minibyte_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic last,
  output logic valid,
  output logic winner
);

  // choose a single winner among the live requests
  always_comb begin
    valid  = cpu_req | dbg_req;
    winner = ID_CPU;
    unique case (1'b1)
      (cpu_req && dbg_req):
        winner = (last == ID_CPU) ? ID_DBG : ID_CPU;
      (!cpu_req && dbg_req):
        winner = ID_DBG;
      default:
        winner = ID_CPU;
    endcase
  end

endmodule

// File: rtl/minibyte_bus_arb.sv
// minibyte bus arbiter: CPU vs debug loader
// setup / access / done cycle on a shared bus
module minibyte_bus_arb
  import minibyte_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter bit CPU_FIRST   = 1'b1
)(
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          ena_in,
  input  logic          cpu_req_in,
  input  logic          dbg_req_in,
  input  logic          cpu_we_in,
  input  logic          dbg_we_in,
  input  logic [DW-1:0] cpu_addr_in,
  input  logic [DW-1:0] dbg_addr_in,
  input  logic [DW-1:0] cpu_wdata_in,
  input  logic [DW-1:0] dbg_wdata_in,
  output logic          cpu_gnt_out,
  output logic          dbg_gnt_out,
  output logic          cpu_ack_out,
  output logic          dbg_ack_out,
  output logic [DW-1:0] rdata_out,
  output logic [DW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_data_out,
  input  logic [DW-1:0] mem_data_in,
  output logic          mem_we_out,
  output logic          mem_drive_out,
  output logic          busy_out
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);
  localparam logic LAST_RST = CPU_FIRST ? ID_DBG : ID_CPU;

  state_t     state;
  state_t     state_nx;
  txn_t       txn;
  logic [2:0] cnt;
  logic       last;
  logic       pick_vld;
  logic       pick_id;
  logic       last_acc;

  minibyte_rr_pick u_pick (
    .cpu_req (cpu_req_in),
    .dbg_req (dbg_req_in),
    .last    (last),
    .valid   (pick_vld),
    .winner  (pick_id)
  );

  assign last_acc = (cnt == LAST_CNT);

  // state register, frozen while disabled
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_IDLE;
    end else if (ena_in) begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (pick_vld) state_nx = ST_SETUP;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: if (last_acc) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // latched transaction, wait counter, read data, last served
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      txn       <= '0;
      cnt       <= 3'd0;
      rdata_out <= '0;
      last      <= LAST_RST;
    end else if (ena_in) begin
      if (state == ST_IDLE && pick_vld) begin
        txn.id    <= pick_id;
        txn.we    <= pick_id ? dbg_we_in : cpu_we_in;
        txn.addr  <= pick_id ? dbg_addr_in : cpu_addr_in;
        txn.wdata <= pick_id ? dbg_wdata_in : cpu_wdata_in;
      end
      if (state == ST_ACCESS && !last_acc) begin
        cnt <= cnt + 3'd1;
      end else begin
        cnt <= 3'd0;
      end
      if (state == ST_ACCESS && last_acc && !txn.we) begin
        rdata_out <= mem_data_in;
      end
      if (state == ST_DONE) begin
        last <= txn.id;
      end
    end
  end

  // bus, grant and ack decode from registered state
  always_comb begin
    cpu_gnt_out   = 1'b0;
    dbg_gnt_out   = 1'b0;
    cpu_ack_out   = 1'b0;
    dbg_ack_out   = 1'b0;
    mem_addr_out  = '0;
    mem_data_out  = '0;
    mem_we_out    = 1'b0;
    mem_drive_out = 1'b0;
    busy_out      = (state != ST_IDLE);
    if (state != ST_IDLE) begin
      cpu_gnt_out = (txn.id == ID_CPU);
      dbg_gnt_out = (txn.id == ID_DBG);
    end
    unique case (state)
      ST_SETUP: begin
        mem_addr_out  = txn.addr;
        mem_data_out  = txn.we ? txn.wdata : '0;
        mem_drive_out = txn.we;
      end
      ST_ACCESS: begin
        mem_addr_out  = txn.addr;
        mem_data_out  = txn.we ? txn.wdata : '0;
        mem_drive_out = txn.we;
        mem_we_out    = txn.we;
      end
      ST_DONE: begin
        cpu_ack_out = (txn.id == ID_CPU);
        dbg_ack_out = (txn.id == ID_DBG);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_minibyte_bus_arb.sv
// minibyte bus arbiter bench
// transaction model with scoreboard and monitor
module tb_minibyte_bus_arb;
  import minibyte_pkg::*;

  localparam int W = 1;
  localparam bit CF = 1'b1;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       ena_in;
  logic       cpu_req_in, dbg_req_in;
  logic       cpu_we_in, dbg_we_in;
  logic [7:0] cpu_addr_in, dbg_addr_in;
  logic [7:0] cpu_wdata_in, dbg_wdata_in;
  logic       cpu_gnt_out, dbg_gnt_out;
  logic       cpu_ack_out, dbg_ack_out;
  logic [7:0] rdata_out;
  logic [7:0] mem_addr_out, mem_data_out;
  logic [7:0] mem_data_in;
  logic       mem_we_out, mem_drive_out, busy_out;

  logic [7:0] mem [256];

  minibyte_bus_arb #(
    .WAIT_CYCLES (W),
    .CPU_FIRST   (CF)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .ena_in        (ena_in),
    .cpu_req_in    (cpu_req_in),
    .dbg_req_in    (dbg_req_in),
    .cpu_we_in     (cpu_we_in),
    .dbg_we_in     (dbg_we_in),
    .cpu_addr_in   (cpu_addr_in),
    .dbg_addr_in   (dbg_addr_in),
    .cpu_wdata_in  (cpu_wdata_in),
    .dbg_wdata_in  (dbg_wdata_in),
    .cpu_gnt_out   (cpu_gnt_out),
    .dbg_gnt_out   (dbg_gnt_out),
    .cpu_ack_out   (cpu_ack_out),
    .dbg_ack_out   (dbg_ack_out),
    .rdata_out     (rdata_out),
    .mem_addr_out  (mem_addr_out),
    .mem_data_out  (mem_data_out),
    .mem_data_in   (mem_data_in),
    .mem_we_out    (mem_we_out),
    .mem_drive_out (mem_drive_out),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  assign mem_data_in = mem[mem_addr_out];

  typedef struct {
    bit         id;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sbq[$];
  exp_t       cur;
  int         rem;
  bit         last_id;
  logic [7:0] exp_rdata;
  int         checks = 0;
  int         errors = 0;
  int         wcnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // transaction-level reference: remaining busy cycles per grant
  initial begin
    rem = 0;
    last_id = CF ? ID_DBG : ID_CPU;
    exp_rdata = 8'h00;
    forever begin
      @(posedge clk_in or negedge rst_n_in);
      if (!rst_n_in) begin
        rem = 0;
        last_id = CF ? ID_DBG : ID_CPU;
        exp_rdata = 8'h00;
        sbq.delete();
      end else if (ena_in) begin
        if (rem == 0) begin
          if (cpu_req_in || dbg_req_in) begin
            if (cpu_req_in && dbg_req_in)
              cur.id = (last_id == ID_CPU) ? ID_DBG : ID_CPU;
            else
              cur.id = dbg_req_in ? ID_DBG : ID_CPU;
            cur.we    = cur.id ? dbg_we_in : cpu_we_in;
            cur.addr  = cur.id ? dbg_addr_in : cpu_addr_in;
            cur.wdata = cur.id ? dbg_wdata_in : cpu_wdata_in;
            cur.rdata = cur.we ? exp_rdata : mem[cur.addr];
            sbq.push_back(cur);
            rem = W + 3;
          end
        end else begin
          if (rem == 2 && !cur.we) exp_rdata = mem[cur.addr];
          if (rem == 1) last_id = cur.id;
          rem--;
        end
      end
    end
  end

  // monitor: compare every cycle, pop the scoreboard on each ack
  initial begin
    bit   eb, es, ea, ed;
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        wcnt = 0;
        chk("rst_outs", int'({cpu_gnt_out, dbg_gnt_out, cpu_ack_out,
            dbg_ack_out, mem_we_out, mem_drive_out, busy_out}), 0);
        chk("rst_bus", int'({mem_addr_out, mem_data_out, rdata_out}), 0);
      end else begin
        eb = (rem > 0);
        es = (rem == W + 3);
        ea = (rem >= 2) && (rem <= W + 2);
        ed = (rem == 1);
        chk("busy", int'(busy_out), int'(eb));
        chk("gnt", int'({cpu_gnt_out, dbg_gnt_out}),
            eb ? (cur.id ? 1 : 2) : 0);
        chk("ack", int'({cpu_ack_out, dbg_ack_out}),
            ed ? (cur.id ? 1 : 2) : 0);
        chk("mem_we", int'(mem_we_out), int'(ea && cur.we));
        chk("drive", int'(mem_drive_out), int'((es || ea) && cur.we));
        chk("rdata", int'(rdata_out), int'(exp_rdata));
        if (!eb) begin
          chk("idle_bus", int'({mem_addr_out, mem_data_out}), 0);
        end else if (es || ea) begin
          chk("addr", int'(mem_addr_out), int'(cur.addr));
        end
        if (mem_we_out) begin
          chk("wdata", int'(mem_data_out), int'(cur.wdata));
          if (ena_in) wcnt++;
        end
        if ((cpu_ack_out || dbg_ack_out) && ena_in) begin
          if (sbq.size() == 0) begin
            chk("sb_empty_on_ack", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("ack_id", int'(dbg_ack_out), int'(e.id));
            chk("ack_rdata", int'(rdata_out), int'(e.rdata));
            chk("we_cycles", wcnt, e.we ? W + 1 : 0);
          end
          wcnt = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_in();
    cpu_req_in = 0; dbg_req_in = 0;
    cpu_we_in = 0; dbg_we_in = 0;
    cpu_addr_in = 0; dbg_addr_in = 0;
    cpu_wdata_in = 0; dbg_wdata_in = 0;
  endtask

  // single transaction; measures cycles from request sample to ack
  task automatic txn(input bit id, input bit we, input logic [7:0] a,
                     input logic [7:0] d, input int frz, input bit chg,
                     output int lat);
    if (id) begin
      dbg_req_in = 1; dbg_we_in = we; dbg_addr_in = a; dbg_wdata_in = d;
    end else begin
      cpu_req_in = 1; cpu_we_in = we; cpu_addr_in = a; cpu_wdata_in = d;
    end
    cyc();
    cpu_req_in = 0;
    dbg_req_in = 0;
    if (chg) begin
      cpu_addr_in = 8'h22;
      dbg_addr_in = 8'h22;
    end
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      if (frz > 0 && k == 2) ena_in = 0;
      if (frz > 0 && k == 2 + frz) ena_in = 1;
      @(negedge clk_in);
      if (ena_in && (cpu_ack_out || dbg_ack_out)) begin
        lat = k;
        break;
      end
      cyc();
    end
    ena_in = 1;
    cyc();
  endtask

  initial begin
    int lat;
    int ak[$];
    int ai[$];
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h5A;
    mem[8'h44] = 8'h96;
    idle_in();
    ena_in = 1;
    rst_n_in = 0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1;
    chk("reset_rdata", int'(rdata_out), 0);
    cyc();

    txn(ID_CPU, 1'b0, 8'h10, 8'h00, 0, 1'b0, lat);
    chk("cpu_rd_lat", lat, W + 3);
    chk("cpu_rd_5a", int'(rdata_out), 8'h5A);

    txn(ID_DBG, 1'b1, 8'h80, 8'hC3, 0, 1'b0, lat);
    chk("dbg_wr_lat", lat, W + 3);
    chk("dbg_wr_keep", int'(rdata_out), 8'h5A);

    txn(ID_CPU, 1'b0, 8'h44, 8'h00, 3, 1'b0, lat);
    chk("frz_lat", lat, W + 6);
    chk("frz_rdata", int'(rdata_out), 8'h96);

    txn(ID_CPU, 1'b1, 8'h44, 8'h3E, 0, 1'b1, lat);
    chk("drop_lat", lat, W + 3);

    cpu_req_in = 1; dbg_req_in = 1;
    cpu_we_in = 0; dbg_we_in = 0;
    rst_n_in = 0;
    cyc();
    rst_n_in = 1;
    @(posedge clk_in);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      if (cpu_ack_out || dbg_ack_out) begin
        ak.push_back(k);
        ai.push_back(int'(dbg_ack_out));
      end
    end
    #1;
    chk("rr_count", ak.size(), 4);
    for (int i = 0; i < 4 && i < ak.size(); i++) begin
      chk("rr_cycle", ak[i], W + 3 + i * (W + 4));
      chk("rr_order", ai[i], i % 2);
    end
    idle_in();
    repeat (8) cyc();

    cpu_req_in = 1; cpu_we_in = 1;
    cpu_addr_in = 8'h55; cpu_wdata_in = 8'hAA;
    cyc();
    cpu_req_in = 0;
    cyc();
    #2;
    chk("wr_we_before_rst", int'(mem_we_out), 1);
    rst_n_in = 0;
    #1;
    chk("async_rst_we", int'(mem_we_out), 0);
    chk("async_rst_ack", int'(cpu_ack_out || dbg_ack_out), 0);
    cyc();
    cpu_req_in = 1; dbg_req_in = 1; cpu_we_in = 0;
    rst_n_in = 1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      if (cpu_ack_out || dbg_ack_out) begin
        lat = int'(dbg_ack_out);
        break;
      end
    end
    chk("post_rst_tie", lat, 0);
    cyc();
    idle_in();
    repeat (8) cyc();

    for (int n = 0; n < 3000; n++) begin
      cpu_req_in = ($urandom_range(0, 9) < 4);
      dbg_req_in = ($urandom_range(0, 9) < 4);
      cpu_we_in = 1'($urandom);
      dbg_we_in = 1'($urandom);
      cpu_addr_in = 8'($urandom);
      dbg_addr_in = 8'($urandom);
      cpu_wdata_in = 8'($urandom);
      dbg_wdata_in = 8'($urandom);
      ena_in = ($urandom_range(0, 9) != 0);
      cyc();
    end
    idle_in();
    ena_in = 1;
    repeat (12) cyc();
    chk("sb_drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
